// File: rtl/dram_refresh_scheduler.sv
// CAS-before-RAS refresh scheduler for the FastRAM array: accrues refresh debt from an
// interval counter and issues refresh bursts only in Zorro II bus-idle windows.
module dram_refresh_scheduler #(
   parameter int unsigned REFRESH_INTERVAL = 109,
   parameter int unsigned MAX_PENDING      = 8,
   parameter int unsigned CAS_CYCLES       = 1,
   parameter int unsigned RAS_CYCLES       = 2,
   parameter int unsigned PRE_CYCLES       = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ASn,
   input  logic       access_active,
   output logic       ref_cas,
   output logic       ref_ras,
   output logic       ref_busy,
   output logic       hold_off,
   output logic [3:0] pending,
   output logic       overflow
);

   localparam int unsigned IntW  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam int unsigned MaxCr = (CAS_CYCLES > RAS_CYCLES) ? CAS_CYCLES : RAS_CYCLES;
   localparam int unsigned MaxPh = (MaxCr > PRE_CYCLES) ? MaxCr : PRE_CYCLES;
   localparam int unsigned PhW   = (MaxPh > 1) ? $clog2(MaxPh) : 1;

   localparam logic [IntW-1:0] IntReload = IntW'(REFRESH_INTERVAL - 1);
   localparam logic [PhW-1:0]  CasLoad   = PhW'(CAS_CYCLES - 1);
   localparam logic [PhW-1:0]  RasLoad   = PhW'(RAS_CYCLES - 1);
   localparam logic [PhW-1:0]  PreLoad   = PhW'(PRE_CYCLES - 1);
   localparam logic [3:0]      MaxPend   = 4'(MAX_PENDING);

   typedef enum logic [1:0] {StIdle, StCas, StRas, StPre} state_e;

   state_e          state_q, state_d;
   logic [IntW-1:0] int_q, int_d;
   logic [PhW-1:0]  ph_q, ph_d;
   logic [3:0]      pend_q, pend_d;
   logic            ovf_q, ovf_d;
   logic            cas_q, cas_d, ras_q, ras_d, busy_q, busy_d, hold_q, hold_d;
   logic            tick, start;

   assign tick  = (int_q == '0);
   assign int_d = tick ? IntReload : int_q - IntW'(1);
   assign start = (state_q == StIdle) && (pend_q != '0) && ASn && !access_active;

   // A tick coinciding with a refresh start cancels out; a tick at saturation is lost.
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (tick && (pend_q == MaxPend)) ovf_d = 1'b1;
      if (tick && !start && (pend_q != MaxPend)) begin
         pend_d = pend_q + 4'd1;
      end else if (start && !tick) begin
         pend_d = pend_q - 4'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCas;
               ph_d    = CasLoad;
            end
         end
         StCas: begin
            if (ph_q == '0) begin
               state_d = StRas;
               ph_d    = RasLoad;
            end else begin
               ph_d = ph_q - PhW'(1);
            end
         end
         StRas: begin
            if (ph_q == '0) begin
               state_d = StPre;
               ph_d    = PreLoad;
            end else begin
               ph_d = ph_q - PhW'(1);
            end
         end
         StPre: begin
            if (ph_q == '0) begin
               state_d = StIdle;
               ph_d    = '0;
            end else begin
               ph_d = ph_q - PhW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            ph_d    = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they leave the block as flop outputs.
   always_comb begin
      cas_d  = (state_d == StCas) || (state_d == StRas);
      ras_d  = (state_d == StRas);
      busy_d = (state_d != StIdle);
      hold_d = busy_d || ((pend_d == MaxPend) && !access_active);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
         int_q   <= IntReload;
         ph_q    <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         cas_q   <= 1'b0;
         ras_q   <= 1'b0;
         busy_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         int_q   <= int_d;
         ph_q    <= ph_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         cas_q   <= cas_d;
         ras_q   <= ras_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
      end
   end

   assign ref_cas  = cas_q;
   assign ref_ras  = ras_q;
   assign ref_busy = busy_q;
   assign hold_off = hold_q;
   assign pending  = pend_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// Bench for dram_refresh_scheduler: expected refresh start cycles are queued as stimulus is
// applied and matched against every rising edge of ref_cas; spot checks cover the rest.
module tb_dram_refresh_scheduler;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       ASn = 1'b1;
   logic       access_active = 1'b0;
   logic       ref_cas, ref_ras, ref_busy, hold_off, overflow;
   logic [3:0] pending;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc;
   int unsigned exp_q[$];

   dram_refresh_scheduler dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .ASn          (ASn),
      .access_active(access_active),
      .ref_cas      (ref_cas),
      .ref_ras      (ref_ras),
      .ref_busy     (ref_busy),
      .hold_off     (hold_off),
      .pending      (pending),
      .overflow     (overflow)
   );

   always #5 CLK = ~CLK;

   // Cycle N is the interval following the Nth posedge after reset release.
   always @(posedge CLK or posedge RESET) begin
      if (RESET) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            prev = 1'b0;
         end else begin
            if (ref_cas && !prev) begin
               if (exp_q.size() == 0) check_eq("start_unexpected", cyc, 32'hFFFF_FFFF);
               else                   check_eq("start_cycle", cyc, exp_q.pop_front());
            end
            prev = ref_cas;
         end
      end
   endtask

   task automatic wait_cyc(input int unsigned n);
      while (cyc < n) @(negedge CLK);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      check_eq("rst_outs", {ref_cas, ref_ras, ref_busy, hold_off, overflow, pending}, 0);
      RESET = 1'b0;
   endtask

   task automatic sb_empty(input string tag);
      check_eq(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      fork
         monitor();
      join_none
      fork
         begin
            #400000;
            $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
            $fatal(1, "timeout");
         end
      join_none

      // Idle bus: periodic single refreshes.
      ASn = 1'b1; access_active = 1'b0;
      do_reset();
      exp_q.push_back(110); exp_q.push_back(219); exp_q.push_back(328);
      wait_cyc(108); check_eq("t1_pend108", pending, 0);
      wait_cyc(109); check_eq("t1_pend109", pending, 1);
      check_eq("t1_hold109", hold_off, 0);
      wait_cyc(110); check_eq("t1_pend110", pending, 0);
      check_eq("t1_cr110", {ref_cas, ref_ras, ref_busy, hold_off}, 4'b1011);
      wait_cyc(111); check_eq("t1_cr111", {ref_cas, ref_ras}, 2'b11);
      wait_cyc(113); check_eq("t1_cr113", {ref_cas, ref_ras, ref_busy}, 3'b001);
      wait_cyc(114); check_eq("t1_busy114", ref_busy, 1);
      wait_cyc(115); check_eq("t1_idle115", {ref_busy, hold_off}, 2'b00);
      wait_cyc(330); sb_empty("t1_sb_empty");

      // Bus busy for 5 intervals, then back-to-back catch-up.
      ASn = 1'b0;
      do_reset();
      wait_cyc(545); check_eq("t2_pend545", pending, 5);
      check_eq("t2_ovf", overflow, 0);
      for (int k = 0; k < 5; k++) exp_q.push_back(546 + 6 * k);
      ASn = 1'b1;
      wait_cyc(546); check_eq("t2_pend546", pending, 4);
      wait_cyc(570); check_eq("t2_pend570", pending, 0);
      wait_cyc(580); sb_empty("t2_sb_empty");

      // Saturation: urgent hold-off and sticky overflow.
      ASn = 1'b0;
      do_reset();
      wait_cyc(871); check_eq("t3_pend871", pending, 7);
      check_eq("t3_hold871", hold_off, 0);
      wait_cyc(872); check_eq("t3_pend872", pending, 8);
      check_eq("t3_hold872", hold_off, 1);
      check_eq("t3_ovf872", overflow, 0);
      wait_cyc(981); check_eq("t3_ovf981", overflow, 1);
      check_eq("t3_pend981", pending, 8);
      wait_cyc(1090); check_eq("t3_pend1090", pending, 8);
      for (int k = 0; k < 8; k++) exp_q.push_back(1091 + 6 * k);
      ASn = 1'b1;
      wait_cyc(1133); check_eq("t3_pend1133", pending, 0);
      check_eq("t3_hold1133", hold_off, 1);
      wait_cyc(1138); check_eq("t3_end", {hold_off, ref_busy, overflow}, 3'b001);
      wait_cyc(1150); sb_empty("t3_sb_empty");

      // Tick coincident with IDLE->CAS.
      ASn = 1'b0;
      do_reset();
      wait_cyc(109); check_eq("t4_pend109", pending, 1);
      wait_cyc(217);
      exp_q.push_back(218); exp_q.push_back(224);
      ASn = 1'b1;
      wait_cyc(218); check_eq("t4_pend218", pending, 1);
      check_eq("t4_cas218", ref_cas, 1);
      wait_cyc(224); check_eq("t4_pend224", pending, 0);
      wait_cyc(230); sb_empty("t4_sb_empty");

      // ASn falls mid-refresh; then an access in progress is not pre-empted.
      ASn = 1'b1; access_active = 1'b0;
      do_reset();
      exp_q.push_back(110);
      wait_cyc(111); ASn = 1'b0;
      check_eq("t5_r111", {ref_ras, hold_off}, 2'b11);
      wait_cyc(112); check_eq("t5_r112", {ref_ras, hold_off}, 2'b11);
      wait_cyc(113); check_eq("t5_r113", {ref_cas, ref_ras, hold_off}, 3'b001);
      wait_cyc(114); check_eq("t5_hold114", hold_off, 1);
      wait_cyc(115); check_eq("t5_r115", {ref_busy, hold_off}, 2'b00);
      access_active = 1'b1;
      wait_cyc(218); check_eq("t5_pend218", pending, 1);
      check_eq("t5_hold218", {hold_off, ref_cas}, 2'b00);
      wait_cyc(230);
      exp_q.push_back(231);
      ASn = 1'b1; access_active = 1'b0;
      wait_cyc(231); check_eq("t5_r231", {ref_cas, pending}, 5'b1_0000);
      wait_cyc(240); sb_empty("t5_sb_empty");

      // Asynchronous reset while in RAS.
      ASn = 1'b0;
      do_reset();
      wait_cyc(436); check_eq("t6_pend436", pending, 4);
      exp_q.push_back(437);
      ASn = 1'b1;
      wait_cyc(438); check_eq("t6_pend438", pending, 3);
      check_eq("t6_ras438", {ref_cas, ref_ras}, 2'b11);
      #2 RESET = 1'b1;
      #1 check_eq("t6_async", {ref_cas, ref_ras, ref_busy, hold_off, overflow, pending}, 0);
      ASn = 1'b0;
      do_reset();
      wait_cyc(108); check_eq("t6_pend108", pending, 0);
      wait_cyc(109); check_eq("t6_pend109", pending, 1);
      sb_empty("t6_sb_empty");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
